// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, write port and reservation port.
// The register file drives the slave side; the issuing logic drives the master side.
interface reg_file_mp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned RD_PORTS   = 2
);
    localparam int unsigned AW = $clog2(REG_NUM);

    logic [RD_PORTS*AW-1:0]         rs_addr;
    logic [RD_PORTS*DATA_WIDTH-1:0] rs_data;
    logic [RD_PORTS-1:0]            rs_busy;
    logic [AW-1:0]                  wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           wr_en;
    logic [AW-1:0]                  rsv_addr;
    logic                           rsv_en;

    modport master (
        output rs_addr, wr_addr, wr_data, wr_en, rsv_addr, rsv_en,
        input  rs_data, rs_busy
    );

    modport slave (
        input  rs_addr, wr_addr, wr_data, wr_en, rsv_addr, rsv_en,
        output rs_data, rs_busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a per-register busy (reservation) bitmap.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned RD_PORTS   = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);
    localparam int unsigned AW = $clog2(REG_NUM);
`ifdef REG_FILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_WIDTH-1:0]          regs_q [REG_NUM];
    logic [DATA_WIDTH-1:0]          regs_d [REG_NUM];
    logic [REG_NUM-1:0]             busy_q;
    logic [REG_NUM-1:0]             busy_d;
    logic [RD_PORTS*DATA_WIDTH-1:0] rs_data_q;
    logic [RD_PORTS*DATA_WIDTH-1:0] rs_data_d;
    logic [RD_PORTS-1:0]            rs_busy_q;
    logic [RD_PORTS-1:0]            rs_busy_d;

    // Register and bitmap update; reservation applied after the write clear so reserve wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            if (bus.wr_en && bus.wr_addr == AW'(r) && !(ZERO_REG != 0 && r == 0)) begin
                regs_d[r] = bus.wr_data;
                busy_d[r] = 1'b0;
            end
        end
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            if (bus.rsv_en && bus.rsv_addr == AW'(r) && !(ZERO_REG != 0 && r == 0)) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    // Read mux; unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        rs_data_d = '0;
        rs_busy_d = '0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                if (bus.rs_addr[p*AW +: AW] == AW'(r)) begin
                    if (BYPASS && bus.wr_en && bus.wr_addr == AW'(r)) begin
                        rs_data_d[p*DATA_WIDTH +: DATA_WIDTH] = regs_d[r];
                        rs_busy_d[p]                          = busy_d[r];
                    end else begin
                        rs_data_d[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
                        rs_busy_d[p]                          = busy_q[r];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                regs_q[r] <= '0;
            end
            busy_q    <= '0;
            rs_data_q <= '0;
            rs_busy_q <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            rs_data_q <= rs_data_d;
            rs_busy_q <= rs_busy_d;
        end
    end

    assign bus.rs_data = rs_data_q;
    assign bus.rs_busy = rs_busy_q;

endmodule
